// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared state encoding and widths for the mole round controller
package mole_pkg;
    localparam int NUM_MOLES = 8;
    localparam int MOLE_W    = 3;
    localparam int UNIT_W    = 8;

    // Last WAIT cycle index before giving up on mole_picker and re-requesting (15 cycles total).
    localparam logic [3:0] WAIT_LAST = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SHOW,
        ST_GAP,
        ST_OVER
    } state_t;
endpackage

// File: rtl/mole_tick_gen.sv
// rtl/mole_tick_gen.sv - prescaler plus unit down-counter; done marks the last cycle of the loaded span
module mole_tick_gen
    import mole_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [UNIT_W-1:0] load_val,
    output logic              done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]     pre;
    logic [UNIT_W-1:0] units;
    logic              tick;

    assign tick = (pre == PW'(TICK_DIV - 1));
    assign done = tick && (units <= UNIT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            units <= '0;
        end else if (clear) begin
            pre   <= '0;
            units <= load_val;
        end else if (tick) begin
            pre <= '0;
            if (units != '0) units <= units - UNIT_W'(1);
        end else begin
            pre <= pre + PW'(1);
        end
    end
endmodule

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round sequencer (request, show, score, gap, game over)
// Define MOLE_SPEEDUP_EN to shorten mole show time as the score rises.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int GAP_UNITS = 1,
    parameter int MAX_MISS  = 3
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    input  logic [MOLE_W-1:0]    mole,
    input  logic [MOLE_W-1:0]    moletime,
    input  logic                 pastenable,
    output logic                 enable,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic                 hit,
    output logic                 miss,
    output logic [7:0]           score,
    output logic                 game_over
);
    state_t               state_q, state_d;
    logic [NUM_MOLES-1:0] btn_prev, btn_edge;
    logic [MOLE_W-1:0]    mole_q;
    logic [3:0]           wait_cnt;
    logic [7:0]           miss_cnt;
    logic [7:0]           score_q;
    logic [UNIT_W-1:0]    base_len, show_len, tg_load;
    logic                 tg_clear, tg_done;
    logic                 do_hit, do_miss, new_game, take_mole, last_miss;

    assign btn_edge  = btn & ~btn_prev;
    assign base_len  = UNIT_W'(moletime) + UNIT_W'(1);
    assign last_miss = (miss_cnt + 8'd1) >= 8'(MAX_MISS);

`ifdef MOLE_SPEEDUP_EN
    logic [UNIT_W-1:0] cut;
    assign cut      = UNIT_W'(score_q[7:3]);
    assign show_len = (cut >= base_len) ? UNIT_W'(1) : base_len - cut;
`else
    assign show_len = base_len;
`endif

    mole_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (CLK100MHZ),
        .rst      (reset),
        .clear    (tg_clear),
        .load_val (tg_load),
        .done     (tg_done)
    );

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        enable    = 1'b0;
        mole_led  = '0;
        game_over = 1'b0;
        tg_clear  = 1'b0;
        tg_load   = UNIT_W'(GAP_UNITS);
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        new_game  = 1'b0;
        take_mole = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                game_over = (state_q == ST_OVER);
                if (start) begin
                    new_game = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                enable  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (pastenable) begin
                    take_mole = 1'b1;
                    tg_clear  = 1'b1;
                    tg_load   = show_len;
                    state_d   = ST_SHOW;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ST_REQ;
                end
            end
            ST_SHOW: begin
                mole_led = NUM_MOLES'(1) << mole_q;
                // A hit landing on the expiry cycle wins; the miss is never recorded.
                if (btn_edge[mole_q]) begin
                    do_hit   = 1'b1;
                    tg_clear = 1'b1;
                    state_d  = ST_GAP;
                end else if (tg_done) begin
                    do_miss  = 1'b1;
                    tg_clear = 1'b1;
                    state_d  = last_miss ? ST_OVER : ST_GAP;
                end
            end
            ST_GAP: begin
                if (tg_done) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            btn_prev <= '0;
            mole_q   <= '0;
            wait_cnt <= '0;
            miss_cnt <= '0;
            score_q  <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
        end else begin
            btn_prev <= btn;
            hit      <= do_hit;
            miss     <= do_miss;
            if (state_q == ST_REQ)       wait_cnt <= '0;
            else if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 4'd1;
            if (take_mole) mole_q <= mole;
            if (new_game) begin
                score_q  <= '0;
                miss_cnt <= '0;
            end else begin
                if (do_hit && score_q != 8'hFF) score_q <= score_q + 8'd1;
                if (do_miss) miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end

    assign score = score_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb/tb_mole_round_ctrl.sv - self-checking bench for mole_round_ctrl with a deadline-based reference model
module tb_mole_round_ctrl;
    localparam int TICK  = 4;
    localparam int GAP_U = 1;
    localparam int MAXM  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pastenable = 1'b0;
    logic [7:0] btn = 8'h00;
    logic [2:0] mole = 3'd0;
    logic [2:0] moletime = 3'd0;
    logic       enable, hit, miss, game_over;
    logic [7:0] mole_led, score;

    int checks = 0;
    int failures = 0;

    mole_round_ctrl #(.TICK_DIV(TICK), .GAP_UNITS(GAP_U), .MAX_MISS(MAXM)) dut (
        .CLK100MHZ  (clk),
        .reset      (rst),
        .start      (start),
        .btn        (btn),
        .mole       (mole),
        .moletime   (moletime),
        .pastenable (pastenable),
        .enable     (enable),
        .mole_led   (mole_led),
        .hit        (hit),
        .miss       (miss),
        .score      (score),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phases advance on absolute edge-number deadlines.
    string      ph = "IDLE";
    int         edge_n = 0, wait_dl = 0, show_dl = 0, gap_dl = 0;
    int         m_score = 0, m_misses = 0, m_mole = 0, m_units = 0;
    logic [7:0] m_prev = 8'h00, m_edges = 8'h00;
    bit         m_hit = 1'b0, m_miss = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            ph = "IDLE"; m_score = 0; m_misses = 0; m_prev = 8'h00;
            m_hit = 1'b0; m_miss = 1'b0; edge_n = 0;
        end else begin
            edge_n++;
            m_edges = btn & ~m_prev;
            m_prev  = btn;
            m_hit   = 1'b0;
            m_miss  = 1'b0;
            if (ph == "IDLE" || ph == "OVER") begin
                if (start) begin m_score = 0; m_misses = 0; ph = "REQ"; end
            end else if (ph == "REQ") begin
                ph = "WAIT"; wait_dl = edge_n + 15;
            end else if (ph == "WAIT") begin
                if (pastenable) begin
                    m_mole  = int'(mole);
                    m_units = int'(moletime) + 1;
`ifdef MOLE_SPEEDUP_EN
                    m_units = m_units - m_score / 8;
                    if (m_units < 1) m_units = 1;
`endif
                    show_dl = edge_n + m_units * TICK;
                    ph = "SHOW";
                end else if (edge_n == wait_dl) begin
                    ph = "REQ";
                end
            end else if (ph == "SHOW") begin
                if (m_edges[m_mole]) begin
                    m_hit = 1'b1;
                    if (m_score < 255) m_score++;
                    ph = "GAP"; gap_dl = edge_n + GAP_U * TICK;
                end else if (edge_n == show_dl) begin
                    m_miss = 1'b1;
                    m_misses++;
                    if (m_misses >= MAXM) ph = "OVER";
                    else begin ph = "GAP"; gap_dl = edge_n + GAP_U * TICK; end
                end
            end else if (ph == "GAP") begin
                if (edge_n == gap_dl) ph = "REQ";
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_enable", enable, int'(ph == "REQ"));
        chk("model_mole_led", mole_led, (ph == "SHOW") ? (1 << m_mole) : 0);
        chk("model_hit", hit, m_hit);
        chk("model_miss", miss, m_miss);
        chk("model_score", score, m_score);
        chk("model_game_over", game_over, int'(ph == "OVER"));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_enable(input string nm);
        int n = 0;
        while (!enable && n < 200) begin tick(); n++; end
        chk({nm, "_enable_seen"}, enable, 1);
    endtask

    task automatic serve(input logic [2:0] m, input logic [2:0] mt);
        wait_enable("serve");
        tick();
        pastenable = 1'b1; mole = m; moletime = mt;
        tick();
        pastenable = 1'b0;
    endtask

    int n, hits_seen, miss_seen, flag;

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_enable", enable, 0);
        chk("rst_mole_led", mole_led, 0);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        chk("rst_score", score, 0);
        chk("rst_game_over", game_over, 0);
        tick();

        start = 1'b1;
        chk("enable_before_start", enable, 0);
        tick();
        start = 1'b0;
        chk("enable_pulse", enable, 1);
        chk("start_led", mole_led, 0);
        chk("start_game_over", game_over, 0);
        tick();
        chk("enable_one_cycle", enable, 0);

        pastenable = 1'b1; mole = 3'd5; moletime = 3'd2;
        tick();
        pastenable = 1'b0;
        n = 0;
        while (mole_led == 8'h20 && n < 40) begin n++; tick(); end
        chk("show_cycles_mt2", n, 12);
        chk("miss_after_show", miss, 1);
        n = 0; flag = 0;
        while (!enable && n < 40) begin
            if (mole_led != 8'h00) flag = 1;
            n++; tick();
        end
        chk("gap_cycles", n, 4);
        chk("gap_led_dark", flag, 0);

        serve(3'd3, 3'd7);
        chk("led_mole3", mole_led, 8'h08);
        tick();
        btn = 8'h08;
        tick();
        btn = 8'h00;
        chk("hit_pulse", hit, 1);
        chk("hit_no_miss", miss, 0);
        chk("score_after_hit", score, 1);
        chk("led_cleared_after_hit", mole_led, 0);

        wait_enable("held");
        btn = 8'h08;
        serve(3'd3, 3'd0);
        hits_seen = 0; miss_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) btn = 8'h0A;
            hits_seen += int'(hit); miss_seen += int'(miss);
            tick();
        end
        btn = 8'h00;
        chk("held_btn_no_hit", hits_seen, 0);
        chk("held_btn_miss", miss_seen, 1);

        serve(3'd6, 3'd0);
        repeat (3) tick();
        btn = 8'h40;
        tick();
        btn = 8'h00;
        chk("expiry_edge_hit", hit, 1);
        chk("expiry_edge_no_miss", miss, 0);
        chk("expiry_edge_score", score, 2);
        chk("expiry_edge_not_over", game_over, 0);

        serve(3'd1, 3'd0);
        repeat (4) tick();
        chk("third_miss_pulse", miss, 1);
        chk("over_after_third_miss", game_over, 1);
        chk("over_score_held", score, 2);

        for (int g = 0; g < 2; g++) begin
            flag = 0;
            for (int i = 0; i < 20; i++) begin flag |= int'(enable); tick(); end
            chk("over_enable_low", flag, 0);
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("restart_enable", enable, 1);
            chk("restart_score", score, 0);
            chk("restart_game_over", game_over, 0);
            if (g == 0) begin
                for (int k = 0; k < 3; k++) begin
                    serve(3'(k), 3'd0);
                    repeat (4) tick();
                    chk("expiry_miss", miss, 1);
                    chk("expiry_game_over", game_over, int'(k == 2));
                end
            end
        end

        n = 1;
        tick();
        while (!enable && n < 40) begin tick(); n++; end
        chk("wait_timeout_cycles", n, 16);

`ifdef MOLE_SPEEDUP_EN
        for (int k = 0; k < 16; k++) begin
            serve(3'(k), 3'd7);
            btn = 8'(1) << (k % 8);
            tick();
            btn = 8'h00;
        end
        chk("speedup_score", score, 16);
        serve(3'd2, 3'd2);
        n = 0;
        while (mole_led == 8'h04 && n < 40) begin n++; tick(); end
        chk("speedup_show_cycles", n, 4);
`endif

        serve(3'd4, 3'd7);
        tick(); tick();
        chk("pre_reset_led", mole_led, 8'h10);
        rst = 1'b1;
        #1;
        chk("midshow_reset_led", mole_led, 0);
        chk("midshow_reset_hit", hit, 0);
        chk("midshow_reset_miss", miss, 0);
        chk("midshow_reset_score", score, 0);
        tick(); tick();
        rst = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            int b;
            start      = ($urandom_range(0, 15) == 0);
            pastenable = ($urandom_range(0, 3) == 0);
            mole       = 3'($urandom);
            moletime   = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                b = int'($urandom_range(0, 7));
                btn[b] = ~btn[b];
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; pastenable = 1'b0; btn = 8'h00;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
